// File: rtl/mc68k_reg_target_if.sv
// mc68k_reg_target_if -- 68000-style register bus between an initiator and a
// register-bank responder. The master drives the strobes, address and write
// data. The slave returns read data, the buffer enable and DTACKn.
interface mc68k_reg_target_if;
  logic        ASn;
  logic        UDSn;
  logic        LDSn;
  logic        RnW;
  logic        REGSELn;
  logic [1:0]  A;
  logic [15:0] D_IN;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic        DTACKn;

  modport master (
    output ASn, UDSn, LDSn, RnW, REGSELn, A, D_IN,
    input  D_OUT, D_OE, DTACKn
  );

  modport slave (
    input  ASn, UDSn, LDSn, RnW, REGSELn, A, D_IN,
    output D_OUT, D_OE, DTACKn
  );
endinterface

// File: rtl/mc68k_reg_target.sv
// mc68k_reg_target -- answers 68000-style bus cycles for four 16-bit local
// registers: CTRL, MASK, STATUS (read-only) and SCRATCH.
// The asynchronous strobes are synchronised into CLK80, and all state changes
// on the falling edge. Reset is synchronous and active-low.
// Optional feature macro: REG_WAIT_EN. When it is defined, CTRL[15:12]
// inserts 0-15 wait cycles before DTACKn is asserted.
module mc68k_reg_target #(
  parameter logic [15:0] CTRL_RST = 16'h0000,
  parameter logic [15:0] MASK_RST = 16'hFFFF
) (
  input  logic               CLK80,
  input  logic               RESETn,
  mc68k_reg_target_if.slave  bus,
  input  logic [15:0]        STATUS_IN,
  output logic [15:0]        CTRL,
  output logic [15:0]        MASK,
  output logic               CTRL_WR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  logic [1:0]  state;
  logic [1:0]  as_sy, uds_sy, lds_sy, sel_sy;
  logic        as_s, uds_s, lds_s, sel_s;
  logic        start;

  // Cycle attributes captured in DECODE. These are used when ACK is entered
  // from WAIT.
  logic        rnw_q;
  logic [1:0]  idx_q;
  logic [15:0] din_q;
  logic        ue_q, le_q;

  logic [15:0] ctrl_q, mask_q, scratch_q;
  logic [15:0] dout_q;
  logic        doe_q, dtack_q, ctrl_wr_q;

  logic        w_rnw, w_ue, w_le;
  logic [1:0]  w_idx;
  logic [15:0] w_data;
  logic        go_wait;
  logic        ack_enter;
  logic        do_write;
  logic [15:0] rd_word;

`ifdef REG_WAIT_EN
  logic [3:0]  wcnt;
`endif

  function automatic logic [15:0] merge(input logic [15:0] old_v,
                                        input logic [15:0] new_v,
                                        input logic ue, input logic le);
    return {ue ? new_v[15:8] : old_v[15:8], le ? new_v[7:0] : old_v[7:0]};
  endfunction

  // Two-flop synchronisers on the asynchronous strobes. These reset to the negated level.
  always_ff @(negedge CLK80) begin
    if (!RESETn) begin
      as_sy  <= 2'b11;
      uds_sy <= 2'b11;
      lds_sy <= 2'b11;
      sel_sy <= 2'b11;
    end else begin
      as_sy  <= {as_sy[0],  bus.ASn};
      uds_sy <= {uds_sy[0], bus.UDSn};
      lds_sy <= {lds_sy[0], bus.LDSn};
      sel_sy <= {sel_sy[0], bus.REGSELn};
    end
  end

  assign as_s  = as_sy[1];
  assign uds_s = uds_sy[1];
  assign lds_s = lds_sy[1];
  assign sel_s = sel_sy[1];
  assign start = !as_s && !sel_s && (!uds_s || !lds_s);

  // Select the write attributes. In DECODE they come straight from the bus;
  // in WAIT they come from the captured copy.
  always_comb begin
    w_rnw  = rnw_q;
    w_idx  = idx_q;
    w_data = din_q;
    w_ue   = ue_q;
    w_le   = le_q;
    if (state == ST_DECODE) begin
      w_rnw  = bus.RnW;
      w_idx  = bus.A;
      w_data = bus.D_IN;
      w_ue   = !uds_s;
      w_le   = !lds_s;
    end
  end

  // Decide when the cycle is acknowledged and whether a register write happens on that edge.
  always_comb begin
`ifdef REG_WAIT_EN
    go_wait   = (ctrl_q[15:12] != 4'd0);
    ack_enter = !as_s && (((state == ST_DECODE) && !go_wait) ||
                          ((state == ST_WAIT) && (wcnt == 4'd0)));
`else
    go_wait   = 1'b0;
    ack_enter = !as_s && (state == ST_DECODE);
`endif
    do_write  = ack_enter && !w_rnw;
  end

  // Read mux, indexed by the live address in DECODE.
  always_comb begin
    case (bus.A)
      2'd0:    rd_word = ctrl_q;
      2'd1:    rd_word = mask_q;
      2'd2:    rd_word = STATUS_IN;
      default: rd_word = scratch_q;
    endcase
  end

  // Register bank. Byte-lane writes land on the edge where ACK is entered.
  // Writes to STATUS are dropped.
  always_ff @(negedge CLK80) begin
    if (!RESETn) begin
      ctrl_q    <= CTRL_RST;
      mask_q    <= MASK_RST;
      scratch_q <= 16'h0000;
    end else if (do_write) begin
      case (w_idx)
        2'd0:    ctrl_q    <= merge(ctrl_q,    w_data, w_ue, w_le);
        2'd1:    mask_q    <= merge(mask_q,    w_data, w_ue, w_le);
        2'd3:    scratch_q <= merge(scratch_q, w_data, w_ue, w_le);
        default: ;
      endcase
    end
  end

  // Cycle state machine: decode, optional wait, acknowledge, and release on AS negation.
  always_ff @(negedge CLK80) begin
    if (!RESETn) begin
      state     <= ST_IDLE;
      dtack_q   <= 1'b1;
      doe_q     <= 1'b0;
      dout_q    <= 16'h0000;
      ctrl_wr_q <= 1'b0;
      rnw_q     <= 1'b1;
      idx_q     <= 2'd0;
      din_q     <= 16'h0000;
      ue_q      <= 1'b0;
      le_q      <= 1'b0;
`ifdef REG_WAIT_EN
      wcnt      <= 4'd0;
`endif
    end else begin
      ctrl_wr_q <= 1'b0;
      if (ack_enter) begin
        state     <= ST_ACK;
        dtack_q   <= 1'b0;
        ctrl_wr_q <= !w_rnw && (w_idx == 2'd0);
      end
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (as_s) begin
            state <= ST_IDLE;
            doe_q <= 1'b0;
          end else begin
            rnw_q <= bus.RnW;
            idx_q <= bus.A;
            din_q <= bus.D_IN;
            ue_q  <= !uds_s;
            le_q  <= !lds_s;
            if (bus.RnW) begin
              dout_q <= rd_word;
              doe_q  <= 1'b1;
            end
`ifdef REG_WAIT_EN
            if (go_wait) begin
              state <= ST_WAIT;
              wcnt  <= ctrl_q[15:12] - 4'd1;
            end
`endif
          end
        end
`ifdef REG_WAIT_EN
        ST_WAIT: begin
          if (as_s) begin
            state <= ST_IDLE;
            doe_q <= 1'b0;
          end else if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end
        end
`endif
        ST_ACK: begin
          if (as_s) begin
            state   <= ST_IDLE;
            dtack_q <= 1'b1;
            doe_q   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.D_OUT  = dout_q;
  assign bus.D_OE   = doe_q;
  assign bus.DTACKn = dtack_q;
  assign CTRL       = ctrl_q;
  assign MASK       = mask_q;
  assign CTRL_WR    = ctrl_wr_q;

endmodule

// File: tb/tb_mc68k_reg_target.sv
// tb_mc68k_reg_target -- directed and random 68000-style cycles. The results
// are checked against a simple register-array model. The expected latencies
// are counted in falling edges from strobe assertion or negation.
module tb_mc68k_reg_target;

  logic        CLK80 = 1'b0;
  logic        RESETn = 1'b0;
  logic [15:0] STATUS_IN;
  logic [15:0] CTRL, MASK;
  logic        CTRL_WR;

  mc68k_reg_target_if bus();

  mc68k_reg_target dut (
    .CLK80     (CLK80),
    .RESETn    (RESETn),
    .bus       (bus.slave),
    .STATUS_IN (STATUS_IN),
    .CTRL      (CTRL),
    .MASK      (MASK),
    .CTRL_WR   (CTRL_WR)
  );

  always #5 CLK80 = ~CLK80;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_reg [4];
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int waits();
`ifdef REG_WAIT_EN
    return int'(m_reg[0][15:12]);
`else
    return 0;
`endif
  endfunction

  task automatic strobes_off();
    bus.ASn = 1'b1; bus.UDSn = 1'b1; bus.LDSn = 1'b1; bus.REGSELn = 1'b1;
  endtask

  // One complete four-phase cycle, checked against the model.
  task automatic cycle(input bit rnw, input logic [1:0] idx, input logic [15:0] data,
                       input bit ue, input bit le);
    int n, early;
    int lat;
    logic [15:0] exp_rd;
    lat    = 4 + waits();
    exp_rd = (idx == 2'd2) ? STATUS_IN : m_reg[idx];
    @(posedge CLK80);
    bus.RnW = rnw; bus.A = idx; bus.D_IN = data;
    bus.REGSELn = 1'b0; bus.UDSn = !ue; bus.LDSn = !le; bus.ASn = 1'b0;
    n = 0; early = 0;
    do begin
      @(negedge CLK80); #1; n++;
      if (bus.DTACKn !== 1'b0 && CTRL_WR !== 1'b0) early++;
    end while (bus.DTACKn !== 1'b0 && n < 40);
    chk("dtack_latency", n, lat);
    chk("ctrl_wr_early", early, 0);
    if (!rnw && idx != 2'd2)
      m_reg[idx] = {ue ? data[15:8] : m_reg[idx][15:8], le ? data[7:0] : m_reg[idx][7:0]};
    chk("ctrl_wr_pulse", CTRL_WR, {31'd0, (!rnw && idx == 2'd0)});
    chk("d_oe_active", bus.D_OE, {31'd0, rnw});
    if (rnw) begin
      chk("d_out_read", bus.D_OUT, exp_rd);
      last_rd = exp_rd;
    end
    chk("ctrl_val", CTRL, m_reg[0]);
    chk("mask_val", MASK, m_reg[1]);
    @(negedge CLK80); #1;
    chk("ctrl_wr_clear", CTRL_WR, 0);
    chk("dtack_hold", bus.DTACKn, 0);
    @(posedge CLK80);
    strobes_off();
    n = 0;
    do begin @(negedge CLK80); #1; n++; end while (bus.DTACKn !== 1'b1 && n < 40);
    chk("dtack_release", n, 3);
    chk("d_oe_release", bus.D_OE, 0);
    chk("d_out_hold", bus.D_OUT, last_rd);
  endtask

  // AS asserted for one clock only. The cycle must not be acknowledged, no
  // register may change, and D_OE must stay low.
  task automatic abort_cycle(input bit rnw, input logic [1:0] idx, input logic [15:0] data);
    int bad;
    @(posedge CLK80);
    bus.RnW = rnw; bus.A = idx; bus.D_IN = data;
    bus.REGSELn = 1'b0; bus.UDSn = 1'b0; bus.LDSn = 1'b0; bus.ASn = 1'b0;
    @(posedge CLK80);
    strobes_off();
    bad = 0;
    repeat (8) begin
      @(negedge CLK80); #1;
      if (bus.DTACKn !== 1'b1 || bus.D_OE !== 1'b0 || CTRL_WR !== 1'b0) bad++;
    end
    chk("abort_no_ack", bad, 0);
    chk("abort_ctrl", CTRL, m_reg[0]);
    chk("abort_mask", MASK, m_reg[1]);
  endtask

  initial begin
    strobes_off();
    bus.RnW = 1'b1; bus.A = 2'd0; bus.D_IN = 16'h0000;
    STATUS_IN = 16'h0000;
    m_reg[0] = 16'h0000; m_reg[1] = 16'hFFFF; m_reg[2] = 16'h0000; m_reg[3] = 16'h0000;
    last_rd = 16'h0000;

    // Reset held for two clocks.
    RESETn = 1'b0;
    repeat (2) @(negedge CLK80);
    #1;
    chk("rst_dtack", bus.DTACKn, 1);
    chk("rst_doe", bus.D_OE, 0);
    chk("rst_dout", bus.D_OUT, 16'h0000);
    chk("rst_ctrl", CTRL, 16'h0000);
    chk("rst_mask", MASK, 16'hFFFF);
    chk("rst_ctrl_wr", CTRL_WR, 0);
    @(posedge CLK80);
    RESETn = 1'b1;

    // Word write to CTRL.
    cycle(1'b0, 2'd0, 16'hA55A, 1'b1, 1'b1);
    // Byte write of the low lane to SCRATCH, then read it back.
    cycle(1'b0, 2'd3, 16'h12FF, 1'b0, 1'b1);
    cycle(1'b1, 2'd3, 16'h0000, 1'b1, 1'b1);
    chk("scratch_byte", last_rd, 16'h00FF);
    // Read STATUS, then write it (acknowledged but ignored), then read it again.
    STATUS_IN = 16'hBEEF;
    cycle(1'b1, 2'd2, 16'h0000, 1'b1, 1'b1);
    chk("status_read", last_rd, 16'hBEEF);
    cycle(1'b0, 2'd2, 16'h1111, 1'b1, 1'b1);
    cycle(1'b1, 2'd2, 16'h0000, 1'b1, 1'b1);
    // Upper-lane-only write to MASK.
    cycle(1'b0, 2'd1, 16'h3C00, 1'b1, 1'b0);
    // Aborted write and aborted read, then a normal cycle to confirm the FSM is back in IDLE.
    abort_cycle(1'b0, 2'd0, 16'h1234);
    abort_cycle(1'b1, 2'd1, 16'h0000);
    cycle(1'b1, 2'd0, 16'h0000, 1'b1, 1'b1);
    // Wait-state field set to 3. The next cycle is longer only when the feature is built in.
    cycle(1'b0, 2'd0, 16'h3000, 1'b1, 1'b1);
    cycle(1'b1, 2'd1, 16'h0000, 1'b1, 1'b1);
    cycle(1'b0, 2'd0, 16'h0000, 1'b1, 1'b1);

    // Random cycles.
    for (int i = 0; i < 24; i++) begin
      logic [1:0] lanes;
      STATUS_IN = 16'($urandom);
      lanes = 2'($urandom_range(1, 3));
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            lanes[1], lanes[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
